// File: rtl/program_sequencer.sv
// Program sequencer: generates the instruction fetch address for the VLIW
// issue stage, with a start/done run handshake, stall, halt and a
// call/return stack whose overflow/underflow parks the sequencer in ERR.
module program_sequencer #(
  parameter int unsigned             PC_WIDTH    = 6,
  parameter int unsigned             STACK_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0]     RESET_ADDR  = '0,
  parameter logic [PC_WIDTH-1:0]     LAST_ADDR   = '1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  input  logic                halt,
  input  logic                jmp_en,
  input  logic                call_en,
  input  logic                ret_en,
  input  logic [PC_WIDTH-1:0] jmp_target,
  output logic [PC_WIDTH-1:0] program_counter,
  output logic                pc_valid,
  output logic                busy,
  output logic                done,
  output logic                stack_err
);

  // Stack pointer must represent 0..STACK_DEPTH; array index covers 0..STACK_DEPTH-1.
  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]      sp_q, sp_d;
  logic [SPW-1:0]      sp_m1;
  logic [AW-1:0]       rd_idx, wr_idx;
  logic                push_en;
  logic [PC_WIDTH-1:0] push_data;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic pc_valid_q, pc_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  assign sp_m1  = sp_q - SPW'(1);
  assign rd_idx = sp_m1[AW-1:0];
  assign wr_idx = sp_q[AW-1:0];

  // Next-state decision: start handshake outside RUN, priority-ordered controls in RUN.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    push_en   = 1'b0;
    push_data = pc_q + PC_WIDTH'(1);

    case (state_q)
      S_RUN: begin
        if (stall) begin
          // hold everything
        end else if (halt) begin
          state_d = S_DONE;
          sp_d    = '0;
        end else if (ret_en) begin
          if (sp_q == '0) begin
            state_d = S_ERR;
            sp_d    = '0;
          end else begin
            pc_d = stack_q[rd_idx];
            sp_d = sp_m1;
          end
        end else if (call_en) begin
          if (sp_q == SP_FULL) begin
            state_d = S_ERR;
            sp_d    = '0;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SPW'(1);
            pc_d    = jmp_target;
          end
        end else if (jmp_en) begin
          pc_d = jmp_target;
        end else if (pc_q == LAST_ADDR) begin
          state_d = S_DONE;
          sp_d    = '0;
        end else begin
          pc_d = pc_q + PC_WIDTH'(1);
        end
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_ADDR;
          sp_d    = '0;
        end
      end
    endcase

    pc_valid_d = (state_d == S_RUN);
    busy_d     = (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  // Control state, PC, stack pointer and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_ADDR;
      sp_q       <= '0;
      pc_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      pc_valid_q <= pc_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[wr_idx] <= push_data;
    end
  end

  assign program_counter = pc_q;
  assign pc_valid        = pc_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign stack_err       = err_q;

endmodule
